// File: rtl/obi_mem_arbiter_if.sv
// OBI-style request/response bundle shared by the masters and the memory port.
interface obi_mem_arbiter_if;
    localparam int unsigned DATA_W = 32;

    logic              proc_req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              mem_rdy;
    logic [DATA_W-1:0] rdata;
    logic              valid;

    // Request issuer: drives the request, receives grant and response
    modport master (
        output proc_req, we, addr, wdata,
        input  mem_rdy, rdata, valid
    );

    // Request receiver: samples the request, returns grant and response
    modport slave (
        input  proc_req, we, addr, wdata,
        output mem_rdy, rdata, valid
    );
endinterface

// File: rtl/obi_mem_arbiter.sv
// Two-to-one arbiter for a shared OBI-style memory port. Master 0 is the
// instruction fetcher, master 1 the load/store unit. Requests are forwarded
// combinationally; an in-order ID FIFO routes each response back to the
// master that issued the matching request.
module obi_mem_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned PRIO_MODE       = 0
) (
    input  logic               CLK,
    input  logic               RST,
    obi_mem_arbiter_if.slave   m0,
    obi_mem_arbiter_if.slave   m1,
    obi_mem_arbiter_if.master  mem,
    output logic               err
);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned DEPTH = 2 ** PTR_W;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    logic [CNT_W-1:0] cnt;
    logic [DEPTH-1:0] id_fifo;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             lock;
    logic             lock_id;
    logic             rr_last;

    logic             gnt_vld;
    logic             gnt_id;
    logic             full;
    logic             accept;
    logic             pop;
    logic             head_id;

    // Pointer advance with wrap at the configured depth (not the power of two)
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Grant selection: a stalled request keeps the port, otherwise arbitrate
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (lock) begin
            gnt_vld = 1'b1;
            gnt_id  = lock_id;
        end else if (m0.proc_req && m1.proc_req) begin
            gnt_vld = 1'b1;
            gnt_id  = (PRIO_MODE == 1) ? 1'b1 : ~rr_last;
        end else if (m1.proc_req) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b1;
        end else if (m0.proc_req) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b0;
        end
    end

    assign full    = (cnt == CNT_MAX);
    assign head_id = id_fifo[rd_ptr];

    // Request path: forward the granted master, blocked while full or in reset
    always_comb begin
        mem.proc_req = 1'b0;
        mem.we       = 1'b0;
        mem.addr     = '0;
        mem.wdata    = '0;
        if (gnt_vld) begin
            mem.proc_req = (gnt_id ? m1.proc_req : m0.proc_req) & ~full & ~RST;
            mem.we       = gnt_id ? m1.we    : m0.we;
            mem.addr     = gnt_id ? m1.addr  : m0.addr;
            mem.wdata    = gnt_id ? m1.wdata : m0.wdata;
        end
    end

    assign accept = mem.proc_req & mem.mem_rdy;
    assign pop    = mem.valid & (cnt != '0) & ~RST;

    // Grant path back to the masters: only the granted one sees mem_rdy
    always_comb begin
        m0.mem_rdy = 1'b0;
        m1.mem_rdy = 1'b0;
        if (gnt_vld && !full && !RST) begin
            m0.mem_rdy = ~gnt_id & mem.mem_rdy;
            m1.mem_rdy =  gnt_id & mem.mem_rdy;
        end
    end

    // Response path: data broadcast, valid steered by the FIFO head
    assign m0.rdata = mem.rdata;
    assign m1.rdata = mem.rdata;
    assign m0.valid = pop & ~head_id;
    assign m1.valid = pop &  head_id;

    // ID FIFO storage and pointers
    always_ff @(posedge CLK) begin
        if (RST) begin
            id_fifo <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            if (accept) begin
                id_fifo[wr_ptr] <= gnt_id;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    // Outstanding transaction count; a simultaneous push and pop cancel
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Arbitration history and request lock while memory stalls
    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_last <= 1'b1;
            lock    <= 1'b0;
            lock_id <= 1'b0;
        end else begin
            if (accept) begin
                rr_last <= gnt_id;
                lock    <= 1'b0;
            end else if (mem.proc_req) begin
                lock    <= 1'b1;
                lock_id <= gnt_id;
            end
        end
    end

    // Sticky flag for a response with nothing outstanding
    always_ff @(posedge CLK) begin
        if (RST) begin
            err <= 1'b0;
        end else if (mem.valid && (cnt == '0)) begin
            err <= 1'b1;
        end
    end
endmodule
